// File: rtl/mmio_uart_tx_if.sv
// Core-side bus port of the memory-mapped UART transmitter.
// The memory map drives the request side; the peripheral returns registered read data.
interface mmio_uart_tx_if;
  logic        sel;
  logic [1:0]  offset;
  logic [31:0] write_data;
  logic [3:0]  write_enable;
  logic [31:0] read_data;

  modport master (
    output sel,
    output offset,
    output write_data,
    output write_enable,
    input  read_data
  );

  modport slave (
    input  sel,
    input  offset,
    input  write_data,
    input  write_enable,
    output read_data
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO, per-frame latched divisor and polled STATUS.
// Register map: 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved.
module mmio_uart_tx #(
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned DEFAULT_DIVISOR = 43
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          uart_tx
);

  localparam int unsigned      PTR_W     = $clog2(FIFO_DEPTH);
  localparam int unsigned      CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      DEF_DIV   = 16'(DEFAULT_DIVISOR);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state;
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             overflow;
  logic [15:0]      divisor;
  logic [15:0]      frame_div;
  logic [15:0]      baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic [31:0]      read_data_q;

  logic        full;
  logic        empty;
  logic        busy;
  logic        pop;
  logic        push_req;
  logic        push_ok;
  logic        status_wr;
  logic        divisor_wr_en;
  logic [15:0] divisor_wr;
  logic [31:0] status;
  logic [31:0] reg_rdata;
  logic        unused_bits;

  assign unused_bits   = ^{bus.write_data[31:16], bus.write_enable[3:2]};
  assign bus.read_data = read_data_q;

  always_comb begin
    full          = (count == DEPTH_CNT);
    empty         = (count == '0);
    busy          = (state != StIdle);
    // The transmitter takes a byte either from idle or straight out of an expiring stop bit.
    pop           = !empty && ((state == StIdle) || ((state == StStop) && (baud_cnt == '0)));
    push_req      = bus.sel && (bus.offset == 2'd0) && bus.write_enable[0];
    push_ok       = push_req && (!full || pop);
    status_wr     = bus.sel && (bus.offset == 2'd1) && bus.write_enable[0];
    divisor_wr_en = bus.sel && (bus.offset == 2'd2) && (|bus.write_enable[1:0]);
    divisor_wr    = {bus.write_enable[1] ? bus.write_data[15:8] : divisor[15:8],
                     bus.write_enable[0] ? bus.write_data[7:0]  : divisor[7:0]};
    if (divisor_wr == '0) begin
      divisor_wr = 16'd1;
    end
    status = {16'b0, 8'(count), 4'b0, overflow, empty, full, busy};
    case (bus.offset)
      2'd1:    reg_rdata = status;
      2'd2:    reg_rdata = {16'b0, divisor};
      default: reg_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= bus.write_data[7:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow    <= 1'b0;
      divisor     <= DEF_DIV;
      read_data_q <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (status_wr && bus.write_data[3]) begin
        overflow <= 1'b0;
      end
      if (divisor_wr_en) begin
        divisor <= divisor_wr;
      end
      // Reads sample pre-write state, so a read-with-write returns the old value.
      read_data_q <= bus.sel ? reg_rdata : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      frame_div <= DEF_DIV;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      uart_tx   <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift     <= fifo_mem[rd_ptr];
            frame_div <= divisor;
            baud_cnt  <= divisor - 16'd1;
            state     <= StStart;
            uart_tx   <= 1'b0;
          end
        end
        StStart: begin
          if (baud_cnt == '0) begin
            baud_cnt <= frame_div - 16'd1;
            bit_cnt  <= '0;
            state    <= StData;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        StData: begin
          if (baud_cnt == '0) begin
            baud_cnt <= frame_div - 16'd1;
            if (bit_cnt == 3'd7) begin
              state   <= StStop;
              uart_tx <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= shift >> 1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        StStop: begin
          if (baud_cnt == '0) begin
            if (pop) begin
              // Back-to-back frame: no idle gap, and the divisor is re-latched here.
              shift     <= fifo_mem[rd_ptr];
              frame_div <= divisor;
              baud_cnt  <= divisor - 16'd1;
              state     <= StStart;
              uart_tx   <= 1'b0;
            end else begin
              state <= StIdle;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: begin
          state   <= StIdle;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: table-driven bus/line sequences plus a randomized run against
// a queue-based reference model of the FIFO, status word and serial line.
module tb_mmio_uart_tx;

  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  logic uart_tx;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(
    .FIFO_DEPTH     (DEPTH),
    .DEFAULT_DIVISOR(43)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k is the cycle index inside a sequence: the op is presented to edge k and checked after it.
  typedef struct {
    int          k;
    logic        sel;
    logic [1:0]  off;
    logic [3:0]  we;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] exp;
  } bus_op_t;

  typedef struct {
    int         start;
    logic [7:0] data;
    int         div;
  } frame_t;

  bus_op_t ops[$];
  frame_t  frames[$];
  int      n_tests;
  int      n_fail;

  // Reference model state for the randomized run.
  logic [7:0]  mq[$];
  bit          m_ovf;
  logic [15:0] m_div;
  int          m_next_free;
  int          m_last_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic void add_op(input int k, input logic sel, input logic [1:0] off,
                                 input logic [3:0] we, input logic [31:0] wd, input bit chk,
                                 input logic [31:0] exp);
    ops.push_back('{k, sel, off, we, wd, chk, exp});
  endfunction

  function automatic void add_frame(input int start, input logic [7:0] data, input int div);
    frames.push_back('{start, data, div});
  endfunction

  // Line level after edge k: start bit, 8 data bits LSB first, stop bit, each div cycles.
  function automatic logic exp_line(input int k);
    foreach (frames[i]) begin
      if (k >= frames[i].start && k < frames[i].start + 10 * frames[i].div) begin
        int idx;
        idx = (k - frames[i].start) / frames[i].div;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return frames[i].data[idx-1];
      end
    end
    return 1'b1;
  endfunction

  task automatic drive_idle();
    bus.sel          = 1'b0;
    bus.offset       = 2'd0;
    bus.write_enable = 4'd0;
    bus.write_data   = 32'd0;
  endtask

  task automatic run_seq(input int ncyc, input string tag);
    for (int k = 0; k < ncyc; k++) begin
      drive_idle();
      foreach (ops[i]) begin
        if (ops[i].k == k) begin
          bus.sel          = ops[i].sel;
          bus.offset       = ops[i].off;
          bus.write_enable = ops[i].we;
          bus.write_data   = ops[i].wd;
        end
      end
      @(posedge clk);
      #1;
      check($sformatf("%s line k=%0d", tag, k), {31'b0, uart_tx}, {31'b0, exp_line(k)});
      foreach (ops[i]) begin
        if (ops[i].k == k && ops[i].chk) begin
          check($sformatf("%s read_data k=%0d", tag, k), bus.read_data, ops[i].exp);
        end
      end
    end
    drive_idle();
    ops.delete();
    frames.delete();
  endtask

  task automatic run_random(input int ncyc, input int nops);
    for (int k = 0; k < ncyc; k++) begin
      logic        s;
      logic [1:0]  o;
      logic [3:0]  w;
      logic [31:0] d;
      logic [31:0] status;
      logic [31:0] exp_rd;
      logic [15:0] nd;
      bit          busy;
      int          r;
      s = 1'b0;
      o = 2'($urandom_range(0, 3));
      w = 4'd0;
      d = $urandom;
      if (k == 0) begin
        s = 1'b1; o = 2'd2; w = 4'b0011; d = 32'd2;
      end else if (k < nops) begin
        r = $urandom_range(0, 99);
        if (r < 30)      begin s = 1'b1; o = 2'd0; w = 4'($urandom_range(0, 15)) | 4'b0001; end
        else if (r < 35) begin s = 1'b1; o = 2'd0; w = 4'($urandom_range(0, 15)) & 4'b1110; end
        else if (r < 55) begin s = 1'b1; o = 2'd1; end
        else if (r < 58) begin s = 1'b1; o = 2'd2; w = 4'b0011; d = 32'($urandom_range(0, 3)); end
        else if (r < 61) begin s = 1'b1; o = 2'd1; w = 4'b0001; end
        else if (r < 66) begin s = 1'b1; o = 2'd2; end
        else if (r < 70) begin s = 1'b1; o = 2'd3; w = 4'($urandom_range(0, 15)); end
        else if (r < 78) begin s = 1'b0; w = 4'($urandom_range(0, 15)); end
      end

      busy   = (m_last_start >= 0) && (m_last_start < k) && (k <= m_next_free);
      status = {16'b0, 8'(mq.size()), 4'b0, m_ovf, mq.size() == 0, mq.size() == DEPTH, busy};
      exp_rd = 32'd0;
      if (s) begin
        case (o)
          2'd1:    exp_rd = status;
          2'd2:    exp_rd = {16'b0, m_div};
          default: exp_rd = 32'd0;
        endcase
      end

      if (mq.size() > 0 && k >= m_next_free) begin
        add_frame(k, mq.pop_front(), int'(m_div));
        m_last_start = k;
        m_next_free  = k + 10 * int'(m_div);
      end
      if (s && o == 2'd0 && w[0]) begin
        if (mq.size() < DEPTH) mq.push_back(d[7:0]);
        else m_ovf = 1'b1;
      end
      if (s && o == 2'd1 && w[0] && d[3]) m_ovf = 1'b0;
      if (s && o == 2'd2 && (w[0] || w[1])) begin
        nd = {w[1] ? d[15:8] : m_div[15:8], w[0] ? d[7:0] : m_div[7:0]};
        m_div = (nd == 16'd0) ? 16'd1 : nd;
      end

      bus.sel          = s;
      bus.offset       = o;
      bus.write_enable = w;
      bus.write_data   = d;
      @(posedge clk);
      #1;
      check($sformatf("rand line k=%0d", k), {31'b0, uart_tx}, {31'b0, exp_line(k)});
      check($sformatf("rand read_data k=%0d", k), bus.read_data, exp_rd);
    end
    drive_idle();
    frames.delete();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    check("reset uart_tx", {31'b0, uart_tx}, 32'd1);
    check("reset read_data", bus.read_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Register access table: sel gating, strobes, reserved space, divisor zero rule.
    add_op(0,  1'b0, 2'd1, 4'h0, 32'h0,          1, 32'h0);
    add_op(1,  1'b1, 2'd1, 4'h0, 32'h0,          1, 32'h4);
    add_op(2,  1'b1, 2'd2, 4'h0, 32'h0,          1, 32'h2B);
    add_op(3,  1'b1, 2'd3, 4'hF, 32'hFFFF_FFFF,  1, 32'h0);
    add_op(4,  1'b1, 2'd3, 4'h0, 32'h0,          1, 32'h0);
    add_op(5,  1'b1, 2'd0, 4'h2, 32'h12,         1, 32'h0);
    add_op(6,  1'b1, 2'd1, 4'h0, 32'h0,          1, 32'h4);
    add_op(7,  1'b1, 2'd2, 4'h3, 32'h0,          1, 32'h2B);
    add_op(8,  1'b1, 2'd2, 4'h0, 32'h0,          1, 32'h1);
    add_op(9,  1'b1, 2'd2, 4'h2, 32'h3400,       1, 32'h1);
    add_op(10, 1'b1, 2'd2, 4'h0, 32'h0,          1, 32'h3401);
    add_op(11, 1'b1, 2'd2, 4'h1, 32'hFF,         1, 32'h3401);
    add_op(12, 1'b1, 2'd2, 4'h0, 32'h0,          1, 32'h34FF);
    add_op(13, 1'b1, 2'd2, 4'hC, 32'hFFFF_0000,  1, 32'h34FF);
    add_op(14, 1'b1, 2'd2, 4'h0, 32'h0,          1, 32'h34FF);
    add_op(15, 1'b0, 2'd2, 4'hF, 32'h0,          1, 32'h0);
    add_op(16, 1'b1, 2'd2, 4'h0, 32'h0,          1, 32'h34FF);
    add_op(17, 1'b1, 2'd2, 4'h3, 32'h2B,         1, 32'h34FF);
    add_op(18, 1'b1, 2'd2, 4'h0, 32'h0,          1, 32'h2B);
    add_op(19, 1'b1, 2'd0, 4'h0, 32'h0,          1, 32'h0);
    run_seq(20, "regs");

    // Single 0xA5 frame at DIVISOR=4, busy through the last stop cycle.
    add_op(0,  1'b1, 2'd2, 4'h3, 32'd4,   0, 32'h0);
    add_op(1,  1'b1, 2'd0, 4'h1, 32'hA5,  0, 32'h0);
    add_op(12, 1'b1, 2'd1, 4'h0, 32'h0,   1, 32'h5);
    add_op(13, 1'b0, 2'd1, 4'h0, 32'h0,   1, 32'h0);
    add_op(42, 1'b1, 2'd1, 4'h0, 32'h0,   1, 32'h5);
    add_op(43, 1'b1, 2'd1, 4'h0, 32'h0,   1, 32'h4);
    add_frame(2, 8'hA5, 4);
    run_seq(46, "single");

    // Ten writes back to back at DIVISOR=2: one in flight, eight buffered, one dropped.
    add_op(0, 1'b1, 2'd2, 4'h3, 32'd2, 0, 32'h0);
    for (int i = 0; i < 10; i++) add_op(1 + i, 1'b1, 2'd0, 4'h1, 32'(i), 0, 32'h0);
    for (int i = 0; i < 9; i++) add_frame(2 + 20 * i, 8'(i), 2);
    add_op(11,  1'b1, 2'd1, 4'h0, 32'h0, 1, 32'h80B);
    add_op(12,  1'b1, 2'd1, 4'h1, 32'h8, 1, 32'h80B);
    add_op(13,  1'b1, 2'd1, 4'h0, 32'h0, 1, 32'h803);
    add_op(14,  1'b0, 2'd1, 4'h0, 32'h0, 1, 32'h0);
    add_op(185, 1'b1, 2'd1, 4'h0, 32'h0, 1, 32'h4);
    run_seq(190, "burst");

    // DIVISOR=0 reads as 1; a mid-frame DIVISOR write only affects the next frame.
    add_op(0,  1'b1, 2'd2, 4'h3, 32'd0,  0, 32'h0);
    add_op(1,  1'b1, 2'd2, 4'h0, 32'h0,  1, 32'h1);
    add_op(2,  1'b1, 2'd0, 4'h1, 32'h3C, 0, 32'h0);
    add_op(3,  1'b1, 2'd0, 4'h1, 32'hC3, 0, 32'h0);
    add_op(4,  1'b1, 2'd2, 4'h3, 32'd8,  0, 32'h0);
    add_op(5,  1'b1, 2'd2, 4'h0, 32'h0,  1, 32'h8);
    add_op(6,  1'b1, 2'd1, 4'h0, 32'h0,  1, 32'h101);
    add_op(95, 1'b1, 2'd1, 4'h0, 32'h0,  1, 32'h4);
    add_frame(3, 8'h3C, 1);
    add_frame(13, 8'hC3, 8);
    run_seq(96, "divisor");

    // Reset asserted during data bit 3 (a low bit of 0xF0) of a DIVISOR=4 frame.
    add_op(0, 1'b1, 2'd2, 4'h3, 32'd4,  0, 32'h0);
    add_op(1, 1'b1, 2'd0, 4'h1, 32'hF0, 0, 32'h0);
    add_frame(2, 8'hF0, 4);
    run_seq(20, "prereset");
    #2;
    reset = 1'b1;
    #1;
    check("async reset uart_tx", {31'b0, uart_tx}, 32'd1);
    check("async reset read_data", bus.read_data, 32'd0);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    add_op(0,   1'b1, 2'd1, 4'h0, 32'h0,  1, 32'h4);
    add_op(1,   1'b1, 2'd2, 4'h0, 32'h0,  1, 32'd43);
    add_op(2,   1'b1, 2'd0, 4'h1, 32'h55, 0, 32'h0);
    add_op(3,   1'b1, 2'd1, 4'h0, 32'h0,  1, 32'h100);
    add_op(440, 1'b1, 2'd1, 4'h0, 32'h0,  1, 32'h4);
    add_frame(3, 8'h55, 43);
    run_seq(442, "postreset");

    // Randomized traffic against the reference model, then an idle drain.
    mq.delete();
    m_ovf        = 1'b0;
    m_div        = 16'd43;
    m_next_free  = 0;
    m_last_start = -1;
    run_random(1100, 800);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data bus, downstream of the core alongside the LED register in the memory map.
- The memory map decodes the peripheral's address window and drives `sel` plus a word offset.
- The block buffers bytes the core writes in a small FIFO and serialises them as 8N1 frames on `uart_tx`.
- Software polls STATUS, so no interrupt output.

Parameters:
- FIFO_DEPTH, 8, number of buffered bytes; power of two, minimum 2.
- DEFAULT_DIVISOR, 43, clk cycles per bit after reset (5 MHz / 115200).

Ports:
- clk  in  1  system clock (core clock domain).
- reset  in  1  asynchronous, active-high reset.
- sel  in  1  bus access targets this peripheral this cycle.
- offset  in  2  word index within window (address[3:2]).
- write_data  in  32  bus write data.
- write_enable  in  4  per-byte write strobes; all zero means read.
- read_data  out  32  registered read data.
- uart_tx  out  1  serial output, idle high.

Behaviour:
- Register map:
  - offset 0 DATA: write byte0 pushes write_data[7:0]; reads 0.
  - offset 1 STATUS, read fields: [0] busy (FSM not IDLE), [1] full, [2] empty, [3] overflow (sticky), [15:8] FIFO count, rest 0.
  - offset 1 STATUS, write: write_enable[0] with write_data[3]=1 clears overflow; other bits ignored.
  - offset 2 DIVISOR: [15:0] R/W, writable per byte via write_enable[1:0]; a written value of 0 is stored as 1.
  - offset 3: reserved; reads 0, writes ignored.
- Accesses are only acted on when sel=1. Writes to DATA with write_enable[0]=0 do nothing.
- read_data is registered: on the edge where sel=1, it loads the addressed register value; otherwise it loads 0. Data is valid one cycle after the access. A read and write in the same cycle return the pre-write value.
- FIFO:
  - Circular buffer with a count register.
  - Push accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the byte is dropped and overflow is set.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - A bit counter (3b) tracks the data bit; a baud counter (16b) counts DIVISOR-1 down to 0.
  - Each state bit lasts exactly DIVISOR clk cycles.
  - IDLE: uart_tx=1. If FIFO is non-empty, pop into the shift register, latch the divisor into the frame copy, and go to START.
  - START: uart_tx=0.
  - DATA: uart_tx=shift[0], LSB first, 8 bits.
  - STOP: uart_tx=1. When it expires, if FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
  - The divisor is latched per frame; a DIVISOR write mid-frame affects the next frame only.
- uart_tx is registered.
  - Write at edge N → FIFO non-empty → pop at edge N+1 → uart_tx falls after edge N+1.
  - Total frame is 10×DIVISOR cycles.
- Reset (async, any time including mid-frame):
  - FIFO empty, pointers/count 0, overflow 0.
  - DIVISOR=DEFAULT_DIVISOR, FSM IDLE, uart_tx=1, read_data=0.
  - The partial frame is abandoned; it is not resent.

Test Plan:
- Single byte: DIVISOR=4, write DATA=0xA5 → uart_tx low 4 cycles starting 2 edges after write, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop high 4 cycles. STATUS busy=1 during frame, busy=0 and empty=1 after 40 cycles.
- Overflow and back-to-back: DIVISOR=2, write 10 bytes in consecutive cycles (0x00..0x09). Required:
  - The first byte pops immediately, 8 are buffered, and the 10th is dropped.
  - STATUS reads overflow=1 and count=8.
  - 9 frames go out with no idle gap, 20 cycles each.
  - Writing STATUS with bit3=1 clears overflow.
- Divisor rules: write DIVISOR=0 → reads back 1, bits last 1 cycle. Write DIVISOR=8 mid-frame → current frame keeps old timing, next frame uses 8.
- Byte strobes and reserved space: write DATA with write_enable=4'b0010 → no push, count stays 0. Write offset 3 → no effect, reads 0. Read with sel=0 → read_data 0.
- Read latency: read STATUS at edge N → correct value on read_data after edge N+1, 0 after edge N+2 if sel deasserted.
- Reset mid-frame: assert reset during DATA bit 3 → uart_tx=1 immediately, STATUS reads empty=1, busy=0, DIVISOR=43. A subsequent write 0x55 transmits correctly.
